fcmp_pipe: RTL

Parametrised, pipelined floating-point comparator for the FPU. Takes two IEEE-style operands of configurable exponent/mantissa width plus an opcode (EQ/LT/LE) and a destination tag. Produces a one-bit result and an invalid flag through a valid/ready pipeline of 1 or 2 stages. Sits between issue and FPU writeback, replacing the single combinational less-than with a full compare unit that handles zeros, NaNs, stalls and flushes.

---
 rtl/fcmp_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fcmp_pipe.sv
// rtl/fcmp_pipe.sv - pipelined floating-point compare (EQ/LT/LE) with valid/ready, flush and tag passthrough
module fcmp_pipe #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [EXP_W+MANT_W:0]     x1,
  input  logic [EXP_W+MANT_W:0]     x2,
  input  logic [1:0]                op,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      y,
  output logic                      invalid,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int W     = 1 + EXP_W + MANT_W;
  localparam int MAG_W = EXP_W + MANT_W;

  logic             s1, s2;
  logic [MAG_W-1:0] mag1, mag2;
  logic             nan1, nan2;
  logic             d_lt, d_eq, d_bz, d_nan;

  assign s1   = x1[W-1];
  assign s2   = x2[W-1];
  assign mag1 = x1[W-2:0];
  assign mag2 = x2[W-2:0];
  assign nan1 = (&x1[W-2:MANT_W]) & (|x1[MANT_W-1:0]);
  assign nan2 = (&x2[W-2:MANT_W]) & (|x2[MANT_W-1:0]);
  assign d_lt  = mag1 < mag2;
  assign d_eq  = mag1 == mag2;
  assign d_bz  = ~(|mag1) & ~(|mag2);
  assign d_nan = nan1 | nan2;

  // Returns {y, invalid}; reserved opcode never raises invalid.
  function automatic logic [1:0] resolve(input logic sa, input logic sb, input logic lt,
                                         input logic eq, input logic bz, input logic nan,
                                         input logic [1:0] o);
    logic lt_o, eq_o, y_o;
    eq_o = bz | ((sa == sb) & eq);
    case ({sa, sb})
      2'b00:   lt_o = lt;
      2'b01:   lt_o = 1'b0;
      2'b10:   lt_o = 1'b1;
      default: lt_o = ~lt & ~eq;
    endcase
    if (bz) lt_o = 1'b0;
    case (o)
      2'd0:    y_o = eq_o;
      2'd1:    y_o = lt_o;
      2'd2:    y_o = lt_o | eq_o;
      default: y_o = 1'b0;
    endcase
    if (nan) y_o = 1'b0;
    return {y_o, nan & (o != 2'd3)};
  endfunction

  generate
    if (STAGES == 1) begin : g_one
      assign in_ready = ~out_valid | out_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid <= 1'b0;
          y         <= 1'b0;
          invalid   <= 1'b0;
          out_tag   <= '0;
        end else if (flush) begin
          out_valid <= 1'b0;
        end else if (in_ready) begin
          out_valid <= in_valid;
          if (in_valid) begin
            {y, invalid} <= resolve(s1, s2, d_lt, d_eq, d_bz, d_nan, op);
            out_tag      <= in_tag;
          end
        end
      end
    end else begin : g_two
      logic             v1;
      logic             r_s1, r_s2, r_lt, r_eq, r_bz, r_nan;
      logic [1:0]       r_op;
      logic [TAG_W-1:0] r_tag;
      logic             ld2;

      // Stage 2 takes a new entry whenever it is empty, so bubbles collapse under backpressure.
      assign ld2      = ~out_valid | out_ready;
      assign in_ready = ~v1 | ld2;

      always_ff @(posedge clk) begin
        if (rst) begin
          v1        <= 1'b0;
          out_valid <= 1'b0;
          y         <= 1'b0;
          invalid   <= 1'b0;
          out_tag   <= '0;
          r_s1      <= 1'b0;
          r_s2      <= 1'b0;
          r_lt      <= 1'b0;
          r_eq      <= 1'b0;
          r_bz      <= 1'b0;
          r_nan     <= 1'b0;
          r_op      <= 2'd0;
          r_tag     <= '0;
        end else if (flush) begin
          v1        <= 1'b0;
          out_valid <= 1'b0;
        end else begin
          if (ld2) begin
            out_valid <= v1;
            if (v1) begin
              {y, invalid} <= resolve(r_s1, r_s2, r_lt, r_eq, r_bz, r_nan, r_op);
              out_tag      <= r_tag;
            end
          end
          if (in_ready) begin
            v1 <= in_valid;
            if (in_valid) begin
              r_s1  <= s1;
              r_s2  <= s2;
              r_lt  <= d_lt;
              r_eq  <= d_eq;
              r_bz  <= d_bz;
              r_nan <= d_nan;
              r_op  <= op;
              r_tag <= in_tag;
            end
          end
        end
      end
    end
  endgenerate

endmodule
